// File: rtl/ece571_cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ece571_cpu_pkg                                                       |
// | Shared types, sizes and ALU helpers for the alu_instruction path.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ece571_cpu_pkg;

  localparam int N           = 32;
  localparam int NREGS       = 16;
  localparam int IMM_SEL_BIT = 0;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100
  } opcode_t;

  typedef struct packed {
    logic [7:0]   instruction;
    logic [3:0]   rs1;
    logic [3:0]   rs2;
    logic [3:0]   rd;
    opcode_t      opcode;
    logic [N-1:0] data;
    logic         we;
  } alu_instruction;

  typedef struct packed {
    logic [3:0]   rd;
    logic [N-1:0] result;
    logic         zero;
    logic         illegal;
  } alu_result_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= 3'b100);
  endfunction

  // Undefined encodings fall through to zero so illegal ops retire cleanly.
  function automatic logic [N-1:0] alu_op(input opcode_t op, input logic [N-1:0] a,
                                          input logic [N-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return '0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_exec_unit_if                                                     |
// | Instruction-in and result-out handshakes of the ALU execution unit.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface alu_exec_unit_if;
  import ece571_cpu_pkg::*;

  logic           in_valid;
  logic           in_ready;
  alu_instruction in_instr;
  logic           out_valid;
  logic           out_ready;
  logic [3:0]     out_rd;
  logic [N-1:0]   out_result;
  logic           out_zero;
  logic           out_illegal;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_rd, out_result, out_zero, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_rd, out_result, out_zero, out_illegal
  );

endinterface
`default_nettype wire

// File: rtl/alu_exec_unit_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_regfile                                                          |
// | NREGS x N register file, R0 hardwired zero, 2 read + debug read port.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_regfile
  import ece571_cpu_pkg::*;
(
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic [3:0]   raddr1,
  output logic      [N-1:0] rdata1,
  input  wire logic [3:0]   raddr2,
  output logic      [N-1:0] rdata2,
  input  wire logic [3:0]   dbg_addr,
  output logic      [N-1:0] dbg_data,
  input  wire logic         we,
  input  wire logic [3:0]   waddr,
  input  wire logic [N-1:0] wdata
);

  logic [N-1:0] r_regs [NREGS];

  // Entry 0 is cleared on reset and never written, so it always reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (we && (waddr != 4'd0)) begin
      r_regs[waddr] <= wdata;
    end
  end

  assign rdata1   = r_regs[raddr1];
  assign rdata2   = r_regs[raddr2];
  assign dbg_data = r_regs[dbg_addr];

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_exec_unit                                                        |
// | Two-stage (decode/operand, execute/result) ALU with write-back.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_exec_unit
  import ece571_cpu_pkg::*;
(
  input  wire logic         clk,
  input  wire logic         rst_n,
  alu_exec_unit_if.slave    bus,
  output logic      [31:0]  retired_count,
  input  wire logic [3:0]   dbg_addr,
  output logic      [N-1:0] dbg_data
);

  logic           r_d_valid;
  alu_instruction r_d_instr;
  logic           r_x_valid;
  alu_result_t    r_x_res;
  logic [31:0]    r_retired_count;

  logic           w_d_advance;
  logic           w_accept;
  logic           w_legal;
  logic           w_wb_en;
  logic [N-1:0]   w_op_a;
  logic [N-1:0]   w_rs2_data;
  logic [N-1:0]   w_op_b;
  logic [N-1:0]   w_result;
  alu_result_t    w_res;

  assign w_d_advance = r_d_valid && (!r_x_valid || bus.out_ready);
  assign bus.in_ready = !r_d_valid || w_d_advance;
  assign w_accept    = bus.in_valid && bus.in_ready;

  alu_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .raddr1   (r_d_instr.rs1),
    .rdata1   (w_op_a),
    .raddr2   (r_d_instr.rs2),
    .rdata2   (w_rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (w_wb_en),
    .waddr    (r_d_instr.rd),
    .wdata    (w_result)
  );

  assign w_op_b   = r_d_instr.instruction[IMM_SEL_BIT] ? r_d_instr.data : w_rs2_data;
  assign w_legal  = is_legal_op(r_d_instr.opcode);
  assign w_result = alu_op(r_d_instr.opcode, w_op_a, w_op_b);

  // Committing on the D->X edge lets the instruction entering D on that
  // same edge read the new value without any forwarding path.
  assign w_wb_en  = w_d_advance && r_d_instr.we && w_legal;

  assign w_res.rd      = r_d_instr.rd;
  assign w_res.result  = w_result;
  assign w_res.zero    = (w_result == '0);
  assign w_res.illegal = !w_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d_valid       <= 1'b0;
      r_d_instr       <= '0;
      r_x_valid       <= 1'b0;
      r_x_res         <= '0;
      r_retired_count <= '0;
    end else begin
      if (w_accept) begin
        r_d_valid <= 1'b1;
        r_d_instr <= bus.in_instr;
      end else if (w_d_advance) begin
        r_d_valid <= 1'b0;
      end

      if (w_d_advance) begin
        r_x_valid <= 1'b1;
        r_x_res   <= w_res;
      end else if (bus.out_ready) begin
        r_x_valid <= 1'b0;
      end

      if (r_x_valid && bus.out_ready) r_retired_count <= r_retired_count + 32'd1;
    end
  end

  assign bus.out_valid   = r_x_valid;
  assign bus.out_rd      = r_x_res.rd;
  assign bus.out_result  = r_x_res.result;
  assign bus.out_zero    = r_x_res.zero;
  assign bus.out_illegal = r_x_res.illegal;
  assign retired_count   = r_retired_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_exec_unit                                                     |
// | Directed vectors with a result scoreboard for alu_exec_unit.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_alu_exec_unit;
  import ece571_cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] retired_count;
  logic [3:0]  dbg_addr;
  logic [N-1:0] dbg_data;

  alu_exec_unit_if ifc ();

  alu_exec_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (ifc),
    .retired_count (retired_count),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  alu_result_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic alu_instruction mk(input logic [2:0] op, input logic [3:0] rs1,
                                        input logic [3:0] rs2, input logic [3:0] rd,
                                        input logic imm, input logic [31:0] data,
                                        input logic we);
    alu_instruction t;
    t.instruction = {7'b0, imm};
    t.rs1 = rs1;
    t.rs2 = rs2;
    t.rd = rd;
    t.opcode = opcode_t'(op);
    t.data = data;
    t.we = we;
    return t;
  endfunction

  function automatic alu_result_t ex(input logic [3:0] rd, input logic [31:0] res,
                                     input logic ill);
    alu_result_t r;
    r.rd = rd;
    r.result = res;
    r.zero = (res == 32'd0);
    r.illegal = ill;
    return r;
  endfunction

  // Monitor: one scoreboard pop per result handshake.
  always @(negedge clk) begin
    if (rst_n && ifc.out_valid && ifc.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 64'(ifc.out_result), 64'hDEAD);
      end else begin
        alu_result_t e;
        e = exp_q.pop_front();
        chk("result", {26'd0, ifc.out_rd, ifc.out_result, ifc.out_zero, ifc.out_illegal},
            {26'd0, e});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input alu_instruction t, input alu_result_t e);
    int budget;
    ifc.in_valid = 1'b1;
    ifc.in_instr = t;
    budget = 0;
    @(negedge clk);
    while (!ifc.in_ready && budget < 50) begin
      budget++;
      @(negedge clk);
    end
    if (!ifc.in_ready) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    ifc.in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || ifc.out_valid) && budget < 50) begin
      budget++;
      @(posedge clk);
      #1;
    end
    chk("drain_timeout", 64'(budget < 50), 64'd1);
  endtask

  task automatic rd_reg(input logic [3:0] a, input logic [31:0] req, input string name);
    dbg_addr = a;
    #1;
    chk(name, 64'(dbg_data), 64'(req));
  endtask

  initial begin
    int accepts;
    logic [31:0] base_cnt;
    logic [31:0] held_res;
    alu_result_t eb[3];

    rst_n = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_instr = '0;
    ifc.out_ready = 1'b1;
    dbg_addr = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(ifc.in_ready), 64'd1);
    chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("rst_retired", 64'(retired_count), 64'd0);
    chk("rst_out_result", 64'(ifc.out_result), 64'd0);
    for (int i = 0; i < NREGS; i++) rd_reg(4'(i), 32'd0, "rst_reg");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Immediate load then dependent use, back to back.
    send(mk(3'b000, 4'd0, 4'd0, 4'd1, 1'b1, 32'h5, 1'b1), ex(4'd1, 32'h5, 1'b0));
    send(mk(3'b000, 4'd1, 4'd0, 4'd2, 1'b1, 32'h3, 1'b1), ex(4'd2, 32'h8, 1'b0));
    chk("first_out_valid", 64'(ifc.out_valid), 64'd1);
    idle();
    #1;
    chk("second_out_valid", 64'(ifc.out_valid), 64'd1);
    drain();
    rd_reg(4'd2, 32'h8, "r2_after_add");
    chk("retired_2", 64'(retired_count), 64'd2);

    // Register-register ops.
    send(mk(3'b000, 4'd0, 4'd0, 4'd1, 1'b1, 32'hF0F0_F0F0, 1'b1), ex(4'd1, 32'hF0F0_F0F0, 1'b0));
    send(mk(3'b000, 4'd0, 4'd0, 4'd2, 1'b1, 32'h0FF0_0FF0, 1'b1), ex(4'd2, 32'h0FF0_0FF0, 1'b0));
    send(mk(3'b010, 4'd1, 4'd2, 4'd4, 1'b0, 32'h0, 1'b0), ex(4'd4, 32'h00F0_00F0, 1'b0));
    send(mk(3'b011, 4'd1, 4'd2, 4'd4, 1'b0, 32'h0, 1'b0), ex(4'd4, 32'hFFF0_FFF0, 1'b0));
    send(mk(3'b100, 4'd1, 4'd2, 4'd4, 1'b0, 32'h0, 1'b0), ex(4'd4, 32'hFF00_FF00, 1'b0));
    send(mk(3'b001, 4'd1, 4'd2, 4'd4, 1'b0, 32'h0, 1'b1), ex(4'd4, 32'hE100_E100, 1'b0));
    send(mk(3'b001, 4'd2, 4'd2, 4'd5, 1'b0, 32'h0, 1'b0), ex(4'd5, 32'h0, 1'b0));
    idle();
    drain();
    rd_reg(4'd4, 32'hE100_E100, "r4_sub");

    // Illegal opcode must not write; R0 discards writes.
    send(mk(3'b000, 4'd0, 4'd0, 4'd3, 1'b1, 32'h1234, 1'b1), ex(4'd3, 32'h1234, 1'b0));
    send(mk(3'b110, 4'd1, 4'd2, 4'd3, 1'b1, 32'h77, 1'b1), ex(4'd3, 32'h0, 1'b1));
    send(mk(3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 32'h7, 1'b1), ex(4'd0, 32'h7, 1'b0));
    idle();
    drain();
    rd_reg(4'd3, 32'h1234, "r3_kept");
    rd_reg(4'd0, 32'h0, "r0_zero");

    // Backpressure with a dependent chain R5 -> R6 -> R7.
    eb[0] = ex(4'd5, 32'h11, 1'b0);
    eb[1] = ex(4'd6, 32'h12, 1'b0);
    eb[2] = ex(4'd7, 32'h13, 1'b0);
    base_cnt = retired_count;
    ifc.out_ready = 1'b0;
    accepts = 0;
    ifc.in_valid = 1'b1;
    ifc.in_instr = mk(3'b000, 4'd0, 4'd0, 4'd5, 1'b1, 32'h11, 1'b1);
    held_res = 32'h0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ifc.in_ready) begin
        @(posedge clk);
        #1;
        exp_q.push_back(eb[accepts]);
        accepts++;
        if (accepts == 1)
          ifc.in_instr = mk(3'b000, 4'd5, 4'd0, 4'd6, 1'b1, 32'h1, 1'b1);
        else
          ifc.in_instr = mk(3'b000, 4'd6, 4'd0, 4'd7, 1'b1, 32'h1, 1'b1);
      end else begin
        if (c >= 2) begin
          if (held_res == 32'h0) held_res = ifc.out_result;
          chk("bp_stable", 64'(ifc.out_result), 64'h11);
        end
        @(posedge clk);
        #1;
      end
    end
    chk("bp_accepts", 64'(accepts), 64'd2);
    chk("bp_in_ready", 64'(ifc.in_ready), 64'd0);
    chk("bp_out_valid", 64'(ifc.out_valid), 64'd1);
    chk("bp_out_rd", 64'(ifc.out_rd), 64'd5);
    chk("bp_held", 64'(held_res), 64'h11);
    chk("bp_no_retire", 64'(retired_count - base_cnt), 64'd0);
    ifc.out_ready = 1'b1;
    send(mk(3'b000, 4'd6, 4'd0, 4'd7, 1'b1, 32'h1, 1'b1), eb[2]);
    idle();
    drain();
    chk("bp_retired", 64'(retired_count - base_cnt), 64'd3);
    rd_reg(4'd7, 32'h13, "r7_chain");

    // Reset with both stages occupied.
    ifc.out_ready = 1'b0;
    send(mk(3'b000, 4'd0, 4'd0, 4'd8, 1'b1, 32'h55, 1'b1), ex(4'd8, 32'h55, 1'b0));
    send(mk(3'b000, 4'd0, 4'd0, 4'd9, 1'b1, 32'h66, 1'b1), ex(4'd9, 32'h66, 1'b0));
    idle();
    chk("full_in_ready", 64'(ifc.in_ready), 64'd0);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mrst_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("mrst_retired", 64'(retired_count), 64'd0);
    chk("mrst_out_fields", {26'd0, ifc.out_rd, ifc.out_result, ifc.out_zero, ifc.out_illegal},
        64'd0);
    chk("mrst_in_ready", 64'(ifc.in_ready), 64'd1);
    rd_reg(4'd8, 32'h0, "mrst_r8");
    rd_reg(4'd9, 32'h0, "mrst_r9");
    ifc.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("post_rst_retired", 64'(retired_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
